// File: rtl/cruise_speed_regulator_if.sv
// ----------------------------------------------------------------------------
// cruise_speed_regulator_if
//
// Bundles every signal exchanged between the cruise regulator and the rest of
// the vehicle: the driver controls, the current speed, the comparator result
// flags coming back, and the regulator's outputs.
//
// Signals
//   speed        [7:0]  current vehicle speed (unsigned)
//   set_btn              latch speed as target and engage (level)
//   inc_btn / dec_btn    target +1 / -1 on each rising edge (level)
//   cancel / brake       disengage
//   G / Eq / L           comparator flags: speed >, ==, < target
//   target       [7:0]  cruise target, feeds comparator b input
//   active               cruise engaged
//   accel_pulse          one-cycle throttle-up request
//   decel_pulse          one-cycle throttle-down request
//   state        [1:0]  IDLE=00, HOLD=01, ACCEL=10, DECEL=11
//   flag_err             previous cycle's flags were not one-hot
//
// Modports
//   master : vehicle / comparator side (drives controls and flags)
//   slave  : the regulator itself
// ----------------------------------------------------------------------------
interface cruise_speed_regulator_if;
  logic [7:0] speed;
  logic       set_btn;
  logic       inc_btn;
  logic       dec_btn;
  logic       cancel;
  logic       brake;
  logic       G;
  logic       Eq;
  logic       L;
  logic [7:0] target;
  logic       active;
  logic       accel_pulse;
  logic       decel_pulse;
  logic [1:0] state;
  logic       flag_err;

  modport master (
    output speed, set_btn, inc_btn, dec_btn, cancel, brake, G, Eq, L,
    input  target, active, accel_pulse, decel_pulse, state, flag_err
  );

  modport slave (
    input  speed, set_btn, inc_btn, dec_btn, cancel, brake, G, Eq, L,
    output target, active, accel_pulse, decel_pulse, state, flag_err
  );
endinterface

// File: rtl/cruise_speed_regulator.sv
// ----------------------------------------------------------------------------
// cruise_speed_regulator
//
// Closed-loop cruise controller. Holds the target speed (driven to the
// comparator's b input), reads back the comparator's G/Eq/L flags and turns a
// persistent "too slow" / "too fast" indication into rate-limited
// accelerate / decelerate pulses. Driver controls engage, cancel and trim the
// target.
//
// Ports
//   clk    : system clock, everything on the rising edge
//   rst_n  : synchronous active-low reset
//   bus    : cruise_speed_regulator_if.slave (controls, flags, outputs)
//
// Parameters
//   HYST_CYCLES : consecutive identical non-Eq samples needed to leave HOLD
//   STEP_DIV    : cycles between successive accel/decel pulses
//   MIN_SPEED   : lowest legal target
//   MAX_SPEED   : highest legal target
// ----------------------------------------------------------------------------
module cruise_speed_regulator #(
  parameter int         HYST_CYCLES = 4,
  parameter int         STEP_DIV    = 8,
  parameter logic [7:0] MIN_SPEED   = 8'd30,
  parameter logic [7:0] MAX_SPEED   = 8'd200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cruise_speed_regulator_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_HOLD  = 2'b01;
  localparam logic [1:0] ST_ACCEL = 2'b10;
  localparam logic [1:0] ST_DECEL = 2'b11;

  // The hysteresis counter may briefly hold HYST_CYCLES+1 (a carried-over G/L
  // sample followed by another when HYST_CYCLES is 1), so size for that.
  localparam int              HCW        = $clog2(HYST_CYCLES + 2);
  localparam int              SCW        = $clog2(STEP_DIV);
  localparam logic [HCW-1:0]  HYST_LIMIT = HCW'(HYST_CYCLES);
  localparam logic [SCW-1:0]  STEP_LAST  = SCW'(STEP_DIV - 1);

  // Direction encoding for the hysteresis run currently being counted.
  localparam logic DIR_G = 1'b0;
  localparam logic DIR_L = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]     state_reg,    state_next;
  logic [7:0]     target_reg,   target_next;
  logic           active_reg,   active_next;
  logic           flag_err_reg, flag_err_next;
  logic           accel_reg,    accel_next;
  logic           decel_reg,    decel_next;
  logic [HCW-1:0] hyst_cnt_reg, hyst_cnt_next;
  logic           hyst_dir_reg, hyst_dir_next;
  logic [SCW-1:0] step_cnt_reg, step_cnt_next;
  logic           inc_prev_reg;
  logic           dec_prev_reg;

  // --------------------------------------------------------------------------
  // Input decode
  // --------------------------------------------------------------------------
  logic flags_valid;
  logic sample_l;
  logic sample_g;
  logic inc_edge;
  logic dec_edge;
  logic set_ok;
  logic stop_req;
  logic inc_ok;
  logic dec_ok;

  // Exactly one flag high: odd parity rules out 0 and 2 set, and the extra
  // term rules out all three.
  assign flags_valid = (bus.G ^ bus.Eq ^ bus.L) & ~(bus.G & bus.Eq & bus.L);
  assign sample_l    = flags_valid & bus.L;
  assign sample_g    = flags_valid & bus.G;

  assign inc_edge = bus.inc_btn & ~inc_prev_reg;
  assign dec_edge = bus.dec_btn & ~dec_prev_reg;

  assign stop_req = bus.brake | bus.cancel;
  assign set_ok   = bus.set_btn && (bus.speed >= MIN_SPEED) && (bus.speed <= MAX_SPEED);

  // A trim request only counts when it actually moves the target; a press
  // at a limit or a simultaneous inc+dec falls through to flag regulation.
  assign inc_ok = active_reg && inc_edge && !dec_edge && (target_reg < MAX_SPEED);
  assign dec_ok = active_reg && dec_edge && !inc_edge && (target_reg > MIN_SPEED);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic [HCW-1:0] hyst_run;

  always_comb begin
    state_next    = state_reg;
    target_next   = target_reg;
    active_next   = active_reg;
    hyst_cnt_next = hyst_cnt_reg;
    hyst_dir_next = hyst_dir_reg;
    hyst_run      = '0;

    // flag_err is reported in every state, including IDLE.
    flag_err_next = ~flags_valid;

    if (stop_req) begin
      state_next    = ST_IDLE;
      active_next   = 1'b0;
      hyst_cnt_next = '0;
    end else if (set_ok) begin
      target_next   = bus.speed;
      state_next    = ST_HOLD;
      active_next   = 1'b1;
      hyst_cnt_next = '0;
    end else if (inc_ok) begin
      target_next   = target_reg + 8'd1;
      state_next    = ST_HOLD;
      hyst_cnt_next = '0;
    end else if (dec_ok) begin
      target_next   = target_reg - 8'd1;
      state_next    = ST_HOLD;
      hyst_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (sample_l || sample_g) begin
            // Extend the run only if it is the same direction as before.
            if ((hyst_cnt_reg != '0) && (hyst_dir_reg == sample_l))
              hyst_run = hyst_cnt_reg + HCW'(1);
            else
              hyst_run = HCW'(1);
            hyst_dir_next = sample_l ? DIR_L : DIR_G;
            if (hyst_run >= HYST_LIMIT) begin
              state_next    = sample_l ? ST_ACCEL : ST_DECEL;
              hyst_cnt_next = '0;
            end else begin
              hyst_cnt_next = hyst_run;
            end
          end else begin
            // Eq or an invalid sample breaks the run.
            hyst_cnt_next = '0;
          end
        end

        ST_ACCEL: begin
          if (!sample_l) begin
            // Leaving on an opposite-direction sample seeds the DECEL run.
            state_next    = ST_HOLD;
            hyst_cnt_next = sample_g ? HCW'(1) : '0;
            hyst_dir_next = DIR_G;
          end
        end

        ST_DECEL: begin
          if (!sample_g) begin
            state_next    = ST_HOLD;
            hyst_cnt_next = sample_l ? HCW'(1) : '0;
            hyst_dir_next = DIR_L;
          end
        end

        default: begin
          // IDLE: flags are ignored.
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Step counter and pulse generation. The counter restarts on every entry
  // into ACCEL/DECEL, so the first pulse lands on the STEP_DIV-th cycle in the
  // state. Pulses are registered from the next-state values so they line up
  // with the state/counter they belong to and never glitch.
  // --------------------------------------------------------------------------
  logic moving_next;

  always_comb begin
    moving_next   = (state_next == ST_ACCEL) || (state_next == ST_DECEL);
    step_cnt_next = '0;
    if (moving_next && (state_next == state_reg)) begin
      if (step_cnt_reg == STEP_LAST)
        step_cnt_next = '0;
      else
        step_cnt_next = step_cnt_reg + SCW'(1);
    end
    accel_next = (state_next == ST_ACCEL) && (step_cnt_next == STEP_LAST);
    decel_next = (state_next == ST_DECEL) && (step_cnt_next == STEP_LAST);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      target_reg   <= 8'd0;
      active_reg   <= 1'b0;
      flag_err_reg <= 1'b0;
      accel_reg    <= 1'b0;
      decel_reg    <= 1'b0;
      hyst_cnt_reg <= '0;
      hyst_dir_reg <= DIR_G;
      step_cnt_reg <= '0;
      inc_prev_reg <= 1'b0;
      dec_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      target_reg   <= target_next;
      active_reg   <= active_next;
      flag_err_reg <= flag_err_next;
      accel_reg    <= accel_next;
      decel_reg    <= decel_next;
      hyst_cnt_reg <= hyst_cnt_next;
      hyst_dir_reg <= hyst_dir_next;
      step_cnt_reg <= step_cnt_next;
      // Button history always tracks the pins so a press held through IDLE
      // or a higher-priority command is not seen as a fresh edge later.
      inc_prev_reg <= bus.inc_btn;
      dec_prev_reg <= bus.dec_btn;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.target      = target_reg;
  assign bus.active      = active_reg;
  assign bus.accel_pulse = accel_reg;
  assign bus.decel_pulse = decel_reg;
  assign bus.state       = state_reg;
  assign bus.flag_err    = flag_err_reg;

endmodule

// File: tb/tb_cruise_speed_regulator.sv
// ----------------------------------------------------------------------------
// tb_cruise_speed_regulator
//
// Directed stimulus with hand-written expected outputs. Each clock the
// stimulus process pushes the expected post-edge outputs into a queue; an
// independent monitor pops one entry per cycle on the falling edge and
// compares it with the DUT.
// ----------------------------------------------------------------------------
module tb_cruise_speed_regulator;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] HOLD  = 2'b01;
  localparam logic [1:0] ACCEL = 2'b10;
  localparam logic [1:0] DECEL = 2'b11;

  typedef struct packed {
    logic [7:0] target;
    logic       active;
    logic       accel;
    logic       decel;
    logic [1:0] state;
    logic       ferr;
  } exp_t;

  logic clk;
  logic rst_n;

  cruise_speed_regulator_if bif ();

  cruise_speed_regulator #(
    .HYST_CYCLES (4),
    .STEP_DIV    (8),
    .MIN_SPEED   (8'd30),
    .MAX_SPEED   (8'd200)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Expected values for the cycle after the next edge.
  logic [7:0] e_target;
  logic       e_active;
  logic       e_accel;
  logic       e_decel;
  logic [1:0] e_state;
  logic       e_ferr;

  task automatic flags(input logic g, input logic e, input logic l);
    bif.G  = g;
    bif.Eq = e;
    bif.L  = l;
  endtask

  task automatic tick(input string nm);
    exp_t e;
    @(posedge clk);
    e.target = e_target;
    e.active = e_active;
    e.accel  = e_accel;
    e.decel  = e_decel;
    e.state  = e_state;
    e.ferr   = e_ferr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        a.target = bif.target;
        a.active = bif.active;
        a.accel  = bif.accel_pulse;
        a.decel  = bif.decel_pulse;
        a.state  = bif.state;
        a.ferr   = bif.flag_err;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got target=%0d active=%0b accel=%0b decel=%0b state=%0d flag_err=%0b, expected target=%0d active=%0b accel=%0b decel=%0b state=%0d flag_err=%0b",
                   nm, a.target, a.active, a.accel, a.decel, a.state, a.ferr,
                   e.target, e.active, e.accel, e.decel, e.state, e.ferr);
        end else begin
          $display("ok   %s: target=%0d active=%0b accel=%0b decel=%0b state=%0d flag_err=%0b",
                   nm, a.target, a.active, a.accel, a.decel, a.state, a.ferr);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Stimulus
  initial begin
    rst_n       = 1'b0;
    bif.speed   = 8'd0;
    bif.set_btn = 1'b0;
    bif.inc_btn = 1'b0;
    bif.dec_btn = 1'b0;
    bif.cancel  = 1'b0;
    bif.brake   = 1'b0;
    flags(1'b0, 1'b1, 1'b0);
    e_target = 8'd0; e_active = 1'b0; e_accel = 1'b0; e_decel = 1'b0;
    e_state  = IDLE; e_ferr   = 1'b0;

    tick("reset0");
    tick("reset1");
    rst_n = 1'b1;
    tick("idle_after_reset");

    // Engage at 100, Eq keeps it in HOLD
    bif.speed = 8'd100; bif.set_btn = 1'b1;
    e_target = 8'd100; e_active = 1'b1; e_state = HOLD;
    tick("set_100");
    bif.set_btn = 1'b0;
    repeat (3) tick("hold_eq");

    // Three L samples then Eq: no transition
    flags(1'b0, 1'b0, 1'b1);
    repeat (3) tick("hold_l_short");
    flags(1'b0, 1'b1, 1'b0);
    tick("hold_eq_breaks_run");

    // Four L samples: ACCEL after the fourth edge
    flags(1'b0, 1'b0, 1'b1);
    repeat (3) tick("hold_l_count");
    e_state = ACCEL;
    tick("enter_accel");
    for (int n = 2; n <= 24; n++) begin
      e_accel = ((n % 8) == 0);
      tick(((n % 8) == 0) ? "accel_pulse" : "accel_wait");
    end
    e_accel = 1'b0;
    flags(1'b0, 1'b1, 1'b0);
    e_state = HOLD;
    tick("accel_eq_to_hold");
    tick("hold_after_accel");

    // DECEL via G, then brake
    flags(1'b1, 1'b0, 1'b0);
    repeat (3) tick("hold_g_count");
    e_state = DECEL;
    tick("enter_decel");
    tick("decel_g");
    tick("decel_g");
    bif.brake = 1'b1;
    e_state = IDLE; e_active = 1'b0;
    tick("brake_to_idle");
    bif.brake = 1'b0;
    tick("idle_flags_ignored");
    bif.speed = 8'd20; bif.set_btn = 1'b1;
    tick("set_out_of_range");
    bif.set_btn = 1'b0;
    bif.inc_btn = 1'b1;
    tick("inc_while_inactive");
    bif.inc_btn = 1'b0;
    tick("idle_release");

    // Target saturation at both ends
    flags(1'b0, 1'b1, 1'b0);
    bif.speed = 8'd199; bif.set_btn = 1'b1;
    e_target = 8'd199; e_active = 1'b1; e_state = HOLD;
    tick("set_199");
    bif.set_btn = 1'b0;
    bif.inc_btn = 1'b1;
    e_target = 8'd200;
    tick("inc_to_200");
    repeat (4) tick("inc_held");
    bif.inc_btn = 1'b0;
    tick("inc_release");
    bif.inc_btn = 1'b1;
    tick("inc_saturated");
    bif.inc_btn = 1'b0;
    tick("inc_release2");
    bif.speed = 8'd31; bif.set_btn = 1'b1;
    e_target = 8'd31;
    tick("set_31");
    bif.set_btn = 1'b0;
    bif.dec_btn = 1'b1;
    e_target = 8'd30;
    tick("dec_to_30");
    bif.dec_btn = 1'b0;
    tick("dec_release");
    bif.dec_btn = 1'b1;
    tick("dec_saturated");
    bif.dec_btn = 1'b0;
    tick("dec_release2");
    bif.inc_btn = 1'b1; bif.dec_btn = 1'b1;
    tick("inc_dec_together");
    bif.inc_btn = 1'b0; bif.dec_btn = 1'b0;
    tick("both_release");

    // Invalid flags in HOLD: flag_err and hysteresis restart
    flags(1'b1, 1'b0, 1'b1);
    e_ferr = 1'b1;
    tick("flags_gl_invalid");
    flags(1'b0, 1'b0, 1'b1);
    e_ferr = 1'b0;
    repeat (3) tick("hold_l_run_a");
    flags(1'b0, 1'b0, 1'b0);
    e_ferr = 1'b1;
    tick("flags_none_invalid");
    flags(1'b0, 1'b0, 1'b1);
    e_ferr = 1'b0;
    repeat (3) tick("hold_l_run_b");
    e_state = ACCEL;
    tick("accel_after_restart");

    // set_btn while accelerating
    tick("accel_c2");
    tick("accel_c3");
    bif.speed = 8'd120; bif.set_btn = 1'b1;
    e_target = 8'd120; e_state = HOLD;
    tick("set_in_accel");
    bif.set_btn = 1'b0;
    repeat (3) tick("hold_l_after_set");
    e_state = ACCEL;
    tick("reenter_accel");
    for (int n = 2; n <= 8; n++) begin
      e_accel = (n == 8);
      tick((n == 8) ? "accel_first_pulse" : "accel_wait2");
    end
    e_accel = 1'b0;

    // G in ACCEL drops to HOLD and counts as the first DECEL sample
    flags(1'b1, 1'b0, 1'b0);
    e_state = HOLD;
    tick("accel_g_to_hold");
    repeat (2) tick("hold_g_carry");
    e_state = DECEL;
    tick("decel_from_carry");
    for (int n = 2; n <= 8; n++) begin
      e_decel = (n == 8);
      tick((n == 8) ? "decel_first_pulse" : "decel_wait");
    end
    e_decel = 1'b0;

    // inc in DECEL forces HOLD and clears hysteresis
    bif.inc_btn = 1'b1;
    e_target = 8'd121; e_state = HOLD;
    tick("inc_in_decel");
    bif.inc_btn = 1'b0;
    repeat (3) tick("hold_g_after_inc");
    e_state = DECEL;
    tick("decel_again");

    // Invalid flags in DECEL drop to HOLD
    flags(1'b1, 1'b1, 1'b0);
    e_state = HOLD; e_ferr = 1'b1;
    tick("decel_invalid_to_hold");
    flags(1'b1, 1'b0, 1'b0);
    e_ferr = 1'b0;
    repeat (3) tick("hold_g_after_invalid");
    e_state = DECEL;
    tick("decel_third");
    repeat (6) tick("decel_wait3");

    // Reset on the edge that would have produced a pulse
    rst_n = 1'b0;
    e_target = 8'd0; e_active = 1'b0; e_state = IDLE;
    tick("reset_mid_decel");
    rst_n = 1'b1;

    // Cancel keeps target
    flags(1'b0, 1'b1, 1'b0);
    bif.speed = 8'd50; bif.set_btn = 1'b1;
    e_target = 8'd50; e_active = 1'b1; e_state = HOLD;
    tick("set_50");
    bif.set_btn = 1'b0;
    bif.cancel = 1'b1;
    e_active = 1'b0; e_state = IDLE;
    tick("cancel_to_idle");
    bif.cancel = 1'b0;
    tick("idle_final");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
